pipe_hazard_sequencer: RTL and testbench

Sequences the 5-stage MIPS pipeline around the main decoder. It detects load-use and branch-operand hazards and inserts bubbles. It freezes the whole pipeline while the data memory is not ready, and it gates the IF flush raised by jumps and taken branches. It sits beside the ID-stage control decoder and drives the PC, IF/ID and ID/EX write/clear enables.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/pipe_hazard_sequencer_hazard_compare.sv | 44 ++++
 rtl/pipe_hazard_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode constants used by the ID-stage
// control decoder and the hazard sequencer, plus the sequencer FSM states.
package mips_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pipe_hazard_sequencer_hazard_compare.sv
// Combinational hazard detection for the instruction in ID.
// Ports:
//   id_opcode, id_rs, id_rt        : instruction currently in ID
//   ex_reg_write, ex_mem_read,
//   ex_rd                          : EX-stage producer
//   mem_mem_read, mem_rd           : MEM-stage load
//   uses_rs, uses_rt               : which source fields the ID opcode reads
//   load_use                       : lw in EX feeds a source of ID
//   br_haz                         : beq in ID needs a value not yet forwardable
module hazard_compare
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    output logic             uses_rs,
    output logic             uses_rt,
    output logic             load_use,
    output logic             br_haz
);

    logic ex_match;
    logic mem_match;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    always_comb begin
        uses_rt   = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) || (id_opcode == OP_SW);
        uses_rs   = (id_opcode != OP_J);
        ex_match  = (ex_rd != '0) &&
                    ((uses_rs && (ex_rd == id_rs)) || (uses_rt && (ex_rd == id_rt)));
        mem_match = (mem_rd != '0) &&
                    ((uses_rs && (mem_rd == id_rs)) || (uses_rt && (mem_rd == id_rt)));
        load_use  = ex_mem_read && ex_match;
        // A lw in EX stalls twice: once here as an EX writer, once as a MEM load.
        br_haz    = (id_opcode == OP_BEQ) &&
                    ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
    end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline sequencer: bubbles on load-use / branch-operand hazards, freezes
// the pipeline while data memory is busy, gates IF flushes, and tracks stall
// and flush performance counters. Control outputs are combinational.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   id_*, ex_*, mem_*              : stage fields used for hazard detection
//   dmem_req, dmem_ready           : data-memory handshake from MEM
//   pc_write, ifid_write           : PC and IF/ID update enables
//   idex_bubble, if_flush          : ID/EX control zeroing, IF/ID clear
//   stall_all                      : freeze ID/EX, EX/MEM, MEM/WB
//   timeout_err                    : sticky data-memory timeout
//   stall_cycles, flush_count      : saturating performance counters
module pipe_hazard_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_br_taken,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             if_flush,
    output logic             stall_all,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(DMEM_TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic uses_rs, uses_rt, load_use, br_haz;
    logic mem_busy;
    logic unused_sigs;

    hazard_compare u_hazard_compare (
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .mem_mem_read (mem_mem_read),
        .mem_rd       (mem_rd),
        .uses_rs      (uses_rs),
        .uses_rt      (uses_rt),
        .load_use     (load_use),
        .br_haz       (br_haz)
    );

    // MEM-stage writes need no stall: they are forwarded or already written.
    assign unused_sigs = ^{mem_reg_write, uses_rs, uses_rt};
    assign mem_busy    = dmem_req && !dmem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Output priority, next-state and counter update.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        err_d       = err_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        if_flush    = 1'b0;
        stall_all   = 1'b0;

        if (state_q == ERROR) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_all   = 1'b1;
        end else if (mem_busy) begin
            // Freeze only: a flush or bubble is re-evaluated once memory releases.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_all  = 1'b1;
        end else if (load_use || br_haz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            if_flush = (id_opcode == OP_J) || ((id_opcode == OP_BEQ) && id_br_taken);
        end

        // Reset cycle: hold fetch, bubble ID/EX, but let the back end drain.
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if_flush    = 1'b0;
            stall_all   = 1'b0;
        end

        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d = RUN;
                end else if (wait_q == WAIT_W'(DMEM_TIMEOUT)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (state_q != ERROR) begin
            if (!pc_write && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (if_flush && (flush_q != '1)) begin
                flush_d = flush_q + CNT_W'(1);
            end
        end
    end

    assign timeout_err  = err_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench for pipe_hazard_sequencer with a scoreboard queue of
// expected per-cycle outputs; counter expectations come from a bench model.
module tb_pipe_hazard_sequencer;
    import mips_pkg::*;

    localparam int unsigned DMEM_TIMEOUT = 15;
    localparam int unsigned CNT_W        = 16;

    logic             clk;
    logic             rst;
    logic [OP_W-1:0]  id_opcode;
    logic [REG_W-1:0] id_rs, id_rt;
    logic             id_br_taken;
    logic             ex_reg_write, ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             mem_reg_write, mem_mem_read;
    logic [REG_W-1:0] mem_rd;
    logic             dmem_req, dmem_ready;
    logic             pc_write, ifid_write, idex_bubble, if_flush, stall_all, timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    pipe_hazard_sequencer #(
        .DMEM_TIMEOUT (DMEM_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_br_taken   (id_br_taken),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_rd        (mem_rd),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .idex_bubble   (idex_bubble),
        .if_flush      (if_flush),
        .stall_all     (stall_all),
        .timeout_err   (timeout_err),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic             pcw;
        logic             ifw;
        logic             bub;
        logic             fl;
        logic             sa;
        logic             err;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t             sb_q[$];
    int unsigned      n_pass  = 0;
    int unsigned      n_fail  = 0;
    int unsigned      n_total = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    task automatic chk(input string tag, input string field,
                       input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic set_id(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rs,
                          input logic [REG_W-1:0] rt, input logic tk);
        id_opcode   = op;
        id_rs       = rs;
        id_rt       = rt;
        id_br_taken = tk;
    endtask

    task automatic set_ex(input logic rw, input logic mr, input logic [REG_W-1:0] rd);
        ex_reg_write = rw;
        ex_mem_read  = mr;
        ex_rd        = rd;
    endtask

    task automatic set_mem(input logic rw, input logic mr, input logic [REG_W-1:0] rd,
                           input logic req, input logic rdy);
        mem_reg_write = rw;
        mem_mem_read  = mr;
        mem_rd        = rd;
        dmem_req      = req;
        dmem_ready    = rdy;
    endtask

    // One cycle: push expectations, compare at negedge, advance past posedge.
    task automatic cyc(input string tag, input logic pcw, input logic bub,
                       input logic fl, input logic sa, input logic err);
        exp_t e;
        e.tag   = tag;
        e.pcw   = pcw;
        e.ifw   = pcw;
        e.bub   = bub;
        e.fl    = fl;
        e.sa    = sa;
        e.err   = err;
        e.stall = m_stall;
        e.flush = m_flush;
        sb_q.push_back(e);
        if (rst) begin
            m_stall = '0;
            m_flush = '0;
        end else if (!err) begin
            if (!pcw && (m_stall != '1)) m_stall = m_stall + CNT_W'(1);
            if (fl && (m_flush != '1))   m_flush = m_flush + CNT_W'(1);
        end
        @(negedge clk);
        e = sb_q.pop_front();
        chk(e.tag, "pc_write",     CNT_W'(pc_write),    CNT_W'(e.pcw));
        chk(e.tag, "ifid_write",   CNT_W'(ifid_write),  CNT_W'(e.ifw));
        chk(e.tag, "idex_bubble",  CNT_W'(idex_bubble), CNT_W'(e.bub));
        chk(e.tag, "if_flush",     CNT_W'(if_flush),    CNT_W'(e.fl));
        chk(e.tag, "stall_all",    CNT_W'(stall_all),   CNT_W'(e.sa));
        chk(e.tag, "timeout_err",  CNT_W'(timeout_err), CNT_W'(e.err));
        chk(e.tag, "stall_cycles", stall_cycles,        e.stall);
        chk(e.tag, "flush_count",  flush_count,         e.flush);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_id(OP_ADDI, 5'd1, 5'd0, 1'b0);
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        cyc("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // lw $2 in EX, add $3,$2,$4 in ID: one bubble
        set_id(OP_RTYPE, 5'd2, 5'd4, 1'b0);
        set_ex(1'b1, 1'b1, 5'd2);
        cyc("load_use", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b0, 1'b0, 5'd0);
        cyc("load_use_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // beq $2,$5 behind lw $2: two stalls, then taken flush
        set_id(OP_BEQ, 5'd2, 5'd5, 1'b0);
        set_ex(1'b1, 1'b1, 5'd2);
        cyc("beq_lw_ex", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd2, 1'b1, 1'b1);
        cyc("beq_lw_mem", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_mem(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        id_br_taken = 1'b1;
        cyc("beq_taken", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // beq on rt behind ALU op in EX: one stall; ALU in MEM is no hazard
        set_id(OP_BEQ, 5'd3, 5'd5, 1'b0);
        set_ex(1'b1, 1'b0, 5'd5);
        cyc("beq_alu_ex", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b0, 5'd5, 1'b0, 1'b1);
        cyc("beq_alu_mem_not_taken", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_mem(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

        // j reads no registers and always flushes
        set_id(OP_J, 5'd2, 5'd0, 1'b0);
        set_ex(1'b1, 1'b1, 5'd2);
        cyc("jump", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // register 0 never creates a hazard
        set_id(OP_RTYPE, 5'd0, 5'd0, 1'b0);
        set_ex(1'b1, 1'b1, 5'd0);
        cyc("reg_zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // sw reads rt, addi does not
        set_id(OP_SW, 5'd1, 5'd7, 1'b0);
        set_ex(1'b1, 1'b1, 5'd7);
        cyc("sw_rt_hazard", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_id(OP_ADDI, 5'd1, 5'd7, 1'b0);
        cyc("addi_rt_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // sw in MEM, ready low for 3 cycles
        set_mem(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("mem_wait3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        cyc("mem_ready", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        cyc("after_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // mem_busy coincident with load_use: freeze, then bubble
        set_id(OP_RTYPE, 5'd2, 5'd4, 1'b0);
        set_ex(1'b1, 1'b1, 5'd2);
        set_mem(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("busy_over_load_use", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        cyc("load_use_after_busy", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        set_id(OP_J, 5'd0, 5'd0, 1'b0);
        cyc("jump_after_bubble", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // flush suppressed while frozen, raised on release
        set_mem(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("busy_over_jump", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        cyc("jump_after_busy", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // DMEM_TIMEOUT+1 busy cycles -> ERROR
        set_mem(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cyc("pre_timeout", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("error", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_ready = 1'b1;
        set_id(OP_J, 5'd0, 5'd0, 1'b0);
        cyc("error_sticky", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        cyc("rst_from_error", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        idle();
        cyc("after_error_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset in the middle of MEM_WAIT
        set_mem(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("wait_before_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cyc("rst_mid_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle();
        cyc("after_mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // exactly DMEM_TIMEOUT busy cycles stays short of the error
        set_mem(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) cyc("wait_15", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        cyc("ready_at_limit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        cyc("final_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
